// File: rtl/wb_master_bridge.sv
// Purpose : single-outstanding request/response to Wishbone classic initiator bridge.
// Latency : handshake edge -> BUS >= 1 cycle -> RESP 1 cycle (misaligned requests skip BUS).
// Backpressure: req_ready_o only in IDLE; response is never stalled (1-cycle resp_valid_o).
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o, req_we_i, req_size_i, req_addr_i, req_wdata_i : request side
//   resp_valid_o, resp_rdata_o, resp_err_o                                 : response side
//   cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, dat_i, ack_i, err_i           : Wishbone initiator
module wb_master_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [3:0]  sel_o,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   // Last BUS cycle index: the counter starts at 0 on BUS entry, so BUS lasts TIMEOUT cycles.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  lo_q, lo_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        misalign;
   logic [31:0] shifted;
   logic [31:0] rd_ext;

   always_comb begin
      misalign = ((req_size_i == 2'd1) && req_addr_i[0])
              || ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00))
              ||  (req_size_i == 2'd3);

      // Lane extraction of read data using the latched low address bits.
      shifted = dat_i >> {lo_q, 3'b000};
      case (size_q)
         2'd0:    rd_ext = {24'h0, shifted[7:0]};
         2'd1:    rd_ext = {16'h0, shifted[15:0]};
         default: rd_ext = shifted;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      size_d       = size_q;
      lo_d         = lo_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid_i && ready_q) begin
               size_d = req_size_i;
               lo_d   = req_addr_i[1:0];
               if (misalign) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else begin
                  state_d = BUS;
                  cnt_d   = 16'h0;
                  cyc_d   = 1'b1;
                  we_d    = req_we_i;
                  adr_d   = {req_addr_i[31:2], 2'b00};
                  case (req_size_i)
                     2'd0: begin
                        sel_d = 4'b0001 << req_addr_i[1:0];
                        dat_d = {4{req_wdata_i[7:0]}};
                     end
                     2'd1: begin
                        sel_d = 4'b0011 << req_addr_i[1:0];
                        dat_d = {2{req_wdata_i[15:0]}};
                     end
                     default: begin
                        sel_d = 4'b1111;
                        dat_d = req_wdata_i;
                     end
                  endcase
               end
            end
         end
         BUS: begin
            // err beats ack, and either beats the timeout in the same cycle.
            if (err_i) begin
               state_d      = RESP;
               cyc_d        = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = 32'h0;
            end else if (ack_i) begin
               state_d      = RESP;
               cyc_d        = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? 32'h0 : rd_ext;
            end else if (cnt_q == TO_LAST) begin
               state_d      = RESP;
               cyc_d        = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 16'h1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cyc_d   = 1'b0;
         end
      endcase

      // Registered ready stays low through reset and rises on the first edge after release.
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= 16'h0;
         ready_q      <= 1'b0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= 4'h0;
         adr_q        <= 32'h0;
         dat_q        <= 32'h0;
         size_q       <= 2'd0;
         lo_q         <= 2'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         size_q       <= size_d;
         lo_q         <= lo_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready_o  = ready_q;
   assign cyc_o        = cyc_q;
   assign stb_o        = cyc_q;
   assign we_o         = we_q;
   assign sel_o        = sel_q;
   assign adr_o        = adr_q;
   assign dat_o        = dat_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
module tb_wb_master_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        cyc_o, stb_o, we_o;
   logic [3:0]  sel_o;
   logic [31:0] adr_o, dat_o;
   logic [31:0] dat_i;
   logic        ack_i, err_i;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // {rdata, err}

   // Slave model controls: kind 0=ack 1=err 2=ack+err 3=never respond
   int          slv_lat  = 0;
   int          slv_kind = 0;
   logic        slv_hold = 1'b0;
   logic [31:0] slv_rdata = 32'h0;

   wb_master_bridge #(.TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
      .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Wishbone slave: acts just after each rising edge based on the BUS cycle count.
   initial begin
      int   n;
      logic hold_pending;
      n = 0;
      hold_pending = 1'b0;
      ack_i = 1'b0;
      err_i = 1'b0;
      dat_i = 32'h0;
      forever begin
         @(posedge clk_i);
         #1;
         dat_i = slv_rdata;
         if (stb_o) begin
            if (n == slv_lat && slv_kind != 3) begin
               ack_i = (slv_kind == 0 || slv_kind == 2);
               err_i = (slv_kind == 1 || slv_kind == 2);
               hold_pending = slv_hold && ack_i;
            end else begin
               ack_i = 1'b0;
               err_i = 1'b0;
            end
            n++;
         end else begin
            n = 0;
            if (hold_pending) begin
               hold_pending = 1'b0;   // ack lingers one cycle after stb drops
            end else begin
               ack_i = 1'b0;
               err_i = 1'b0;
            end
         end
      end
   end

   // Response monitor: every resp_valid_o pops one expected response.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk_i);
         if (resp_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_resp: got rdata=0x%08h err=%0b expected no response", resp_rdata_o, resp_err_o);
            end else begin
               e = exp_q.pop_front();
               chk("resp_rdata", resp_rdata_o, e[32:1]);
               chk("resp_err", {31'h0, resp_err_o}, {31'h0, e[0]});
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_bus, input logic [3:0] exp_sel,
                         input logic [31:0] exp_adr, input logic [31:0] exp_dat,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_cycles);
      int n;
      int bus_n;
      n = 0;
      while (!req_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("req_ready_wait", {31'h0, req_ready_o}, 32'h1);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_size_i  = sz;
      req_addr_i  = addr;
      req_wdata_i = wd;
      exp_q.push_back({exp_rd, exp_err});
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("ready_low_after_hs", {31'h0, req_ready_o}, 32'h0);
      if (exp_bus) begin
         chk("cyc_stb", {30'h0, cyc_o, stb_o}, 32'h3);
         chk("sel", {28'h0, sel_o}, {28'h0, exp_sel});
         chk("adr", adr_o, exp_adr);
         chk("dat", dat_o, exp_dat);
         chk("we", {31'h0, we_o}, {31'h0, we});
         bus_n = 0;
         while (cyc_o && bus_n < 100) begin
            bus_n++;
            @(negedge clk_i);
         end
         chk("bus_cycles", bus_n, exp_cycles);
      end else begin
         chk("no_cyc", {30'h0, cyc_o, stb_o}, 32'h0);
      end
      chk("resp_valid", {31'h0, resp_valid_o}, 32'h1);
      @(negedge clk_i);
      chk("resp_one_cycle", {31'h0, resp_valid_o}, 32'h0);
      chk("ready_after_resp", {31'h0, req_ready_o}, 32'h1);
   endtask

   initial begin
      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      req_size_i  = 2'd0;
      req_addr_i  = 32'h0;
      req_wdata_i = 32'h0;
      repeat (2) @(negedge clk_i);
      chk("rst_ready", {31'h0, req_ready_o}, 32'h0);
      chk("rst_wb", {29'h0, cyc_o, stb_o, we_o}, 32'h0);
      chk("rst_sel", {28'h0, sel_o}, 32'h0);
      chk("rst_adr_dat", adr_o | dat_o, 32'h0);
      chk("rst_resp", {30'h0, resp_valid_o, resp_err_o}, 32'h0);
      chk("rst_rdata", resp_rdata_o, 32'h0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("ready_after_release", {31'h0, req_ready_o}, 32'h1);

      // word write, ack one cycle after stb
      slv_kind = 0; slv_lat = 1; slv_rdata = 32'hFFFF_FFFF;
      do_req(1, 2'd2, 32'h100, 32'hDEADBEEF, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
      // byte read at lane 3
      slv_lat = 0; slv_rdata = 32'h12345678;
      do_req(0, 2'd0, 32'h103, 32'h000000AB, 1, 4'b1000, 32'h100, 32'hABABABAB, 32'h12, 0, 1);
      // misaligned half, illegal size
      do_req(1, 2'd1, 32'h201, 32'h1234, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      do_req(0, 2'd3, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      // half read upper lane, ack after 2 wait cycles
      slv_lat = 2; slv_rdata = 32'hCAFEF00D;
      do_req(0, 2'd1, 32'h102, 32'h00001234, 1, 4'b1100, 32'h100, 32'h12341234, 32'hCAFE, 0, 3);
      // byte write lane 1 returns zero data
      slv_lat = 0; slv_rdata = 32'h77777777;
      do_req(1, 2'd0, 32'h101, 32'h0000005A, 1, 4'b0010, 32'h100, 32'h5A5A5A5A, 32'h0, 0, 1);
      // word read
      slv_rdata = 32'h89ABCDEF;
      do_req(0, 2'd2, 32'h200, 32'h0, 1, 4'hF, 32'h200, 32'h0, 32'h89ABCDEF, 0, 1);
      // timeout after 4 BUS cycles
      slv_kind = 3;
      do_req(0, 2'd2, 32'h300, 32'h0, 1, 4'hF, 32'h300, 32'h0, 32'h0, 1, 4);
      // ack in the timeout cycle wins
      slv_kind = 0; slv_lat = 3; slv_rdata = 32'h0BADF00D;
      do_req(0, 2'd2, 32'h304, 32'h0, 1, 4'hF, 32'h304, 32'h0, 32'h0BADF00D, 0, 4);
      // ack and err together -> error
      slv_kind = 2; slv_lat = 0; slv_rdata = 32'h11111111;
      do_req(0, 2'd2, 32'h308, 32'h0, 1, 4'hF, 32'h308, 32'h0, 32'h0, 1, 1);
      // err alone
      slv_kind = 1; slv_lat = 1;
      do_req(1, 2'd2, 32'h30C, 32'h01020304, 1, 4'hF, 32'h30C, 32'h01020304, 32'h0, 1, 2);
      // slave holding ack an extra cycle, back-to-back requests
      slv_kind = 0; slv_lat = 0; slv_hold = 1'b1; slv_rdata = 32'h11223344;
      do_req(0, 2'd0, 32'h000, 32'h0, 1, 4'b0001, 32'h0, 32'h0, 32'h44, 0, 1);
      do_req(0, 2'd0, 32'h001, 32'h0, 1, 4'b0010, 32'h0, 32'h0, 32'h33, 0, 1);
      do_req(0, 2'd2, 32'h002, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      do_req(0, 2'd1, 32'h002, 32'h0, 1, 4'b1100, 32'h0, 32'h0, 32'h1122, 0, 1);
      slv_hold = 1'b0;

      // reset in the middle of a BUS cycle
      slv_kind = 3;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2;
      req_addr_i = 32'h500; req_wdata_i = 32'h0;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("midbus_cyc", {30'h0, cyc_o, stb_o}, 32'h3);
      #2;
      rst_i = 1'b0;
      #1;
      chk("async_drop_cyc", {30'h0, cyc_o, stb_o}, 32'h0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_no_resp", {31'h0, resp_valid_o}, 32'h0);
      chk("rst_ready_low", {31'h0, req_ready_o}, 32'h0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("ready_first_after_rst", {31'h0, req_ready_o}, 32'h1);
      slv_kind = 0; slv_lat = 1; slv_rdata = 32'h55AA55AA;
      do_req(0, 2'd2, 32'h400, 32'h0, 1, 4'hF, 32'h400, 32'h0, 32'h55AA55AA, 0, 2);

      repeat (3) @(negedge clk_i);
      chk("queue_drained", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max BUS-state cycles waiting for ack_i/err_i before abort (legal 1..65535).
REQ-002 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  input  1 (request present), req_ready_o  output  1 (bridge accepts request).
REQ-005 SHALL have req_we_i  input  1 (1 = write), req_size_i  input  2 (0 byte, 1 half, 2 word, 3 illegal).
REQ-006 SHALL have req_addr_i  input  32 (byte address), req_wdata_i  input  32 (write data, LSB-aligned).
REQ-007 SHALL have resp_valid_o  output  1, resp_rdata_o  output  32, resp_err_o  output  1.
REQ-008 SHALL have Wishbone initiator ports: cyc_o, stb_o, we_o  output  1; sel_o  output  4; adr_o, dat_o  output  32; dat_i  input  32; ack_i, err_i  input  1.

Function
REQ-009 SHALL implement states IDLE, BUS, RESP; all outputs registered.
REQ-010 SHALL assert req_ready_o only in IDLE; handshake = req_valid_i & req_ready_o at rising edge, latching we, size, addr, wdata.
REQ-011 SHALL classify as misaligned: size 1 with addr[0]=1, size 2 with addr[1:0]!=0, size 3 any address.
REQ-012 Misaligned request SHALL go IDLE->RESP with resp_err_o=1, resp_rdata_o=0, no Wishbone cycle.
REQ-013 Aligned request SHALL go IDLE->BUS; cyc_o=stb_o=1 from the next cycle, held constant until BUS exits.
REQ-014 SHALL drive adr_o={addr[31:2],2'b00}; we_o=latched we.
REQ-015 SHALL drive sel_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-016 SHALL drive dat_o: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-017 In BUS, ack_i=1 SHALL move to RESP, capture dat_i, drop cyc_o/stb_o next cycle, set resp_err_o=0.
REQ-018 In BUS, err_i=1 SHALL move to RESP with resp_err_o=1, resp_rdata_o=0; err_i wins over simultaneous ack_i.
REQ-019 SHALL count BUS cycles with a 16-bit counter cleared on BUS entry; counter reaching TIMEOUT with no ack_i/err_i SHALL abort to RESP with resp_err_o=1; ack_i/err_i in that same cycle SHALL take priority over timeout.
REQ-020 Read data SHALL be dat_i >> (8*addr[1:0]), zero-extended to 8 (byte) or 16 (half) bits; write responses return resp_rdata_o=0.
REQ-021 RESP SHALL last exactly one cycle with resp_valid_o=1, then IDLE; no back-pressure on response.
REQ-022 ack_i/err_i outside BUS SHALL be ignored (tolerates registered-ack slaves holding ack one extra cycle).
REQ-023 Minimum aligned transaction: handshake edge, BUS >= 1 cycle, RESP 1 cycle; next request accepted no earlier than the cycle after RESP.
REQ-024 resp_rdata_o/resp_err_o SHALL hold last values outside RESP; only resp_valid_o qualifies them.

Reset
REQ-025 rst_i=0 SHALL asynchronously force IDLE, counter 0, cyc_o=stb_o=we_o=0, sel_o=0, adr_o=dat_o=0, resp_valid_o=resp_err_o=0, resp_rdata_o=0, req_ready_o=0 while asserted.
REQ-026 Reset during BUS SHALL drop cyc_o/stb_o immediately and discard the transaction with no response; req_ready_o=1 first cycle after release.

Verification
REQ-027 Word write addr 0x100, wdata 0xDEADBEEF, slave acks 1 cycle after stb -> sel_o=4'hF, dat_o=0xDEADBEEF, resp_valid_o one cycle, resp_err_o=0.
REQ-028 Byte read addr 0x103, dat_i=0x12345678 -> sel_o=4'b1000, adr_o=0x100, resp_rdata_o=0x00000012.
REQ-029 Half write addr 0x201 -> no cyc_o, resp_valid_o with resp_err_o=1 one cycle after handshake; size 3 at 0x0 -> same.
REQ-030 TIMEOUT=4, slave never acks -> cyc_o drops after 4 BUS cycles, resp_err_o=1; ack_i and err_i together -> resp_err_o=1.
REQ-031 Slave holding ack_i one extra cycle after stb_o drops, back-to-back requests -> exactly one response per request, no spurious completion.
REQ-032 rst_i low mid-BUS -> cyc_o=stb_o=0 same cycle asynchronously, no resp_valid_o, next request completes normally.
